// File: rtl/friscv_bridge_pkg.sv
// friscv_bridge_pkg: response codes and FSM state shared by the AXI4-lite to APB bridge.
package friscv_bridge_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

endpackage

// File: rtl/friscv_bridge_rr_arb.sv
// friscv_rr_arb2: two-request round-robin arbiter; a collision goes to the opposite of the last grant.
module friscv_rr_arb2 (
    input  logic       aclk,
    input  logic       areset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    // last_gnt = 1 means req[1] was granted last, so req[0] wins the next collision
    logic last_gnt;

    always_comb begin
        grant[0] = en && req[0] && (!req[1] || last_gnt);
        grant[1] = en && req[1] && (!req[0] || !last_gnt);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            last_gnt <= 1'b1;
        else if (grant[0])
            last_gnt <= 1'b0;
        else if (grant[1])
            last_gnt <= 1'b1;
    end

endmodule

// File: rtl/friscv_axil_apb_bridge.sv
// friscv_axil_apb_bridge: AXI4-lite slave to APB-style master, one access in flight, window decode.
// Define FRISCV_BRIDGE_TIMEOUT_EN to abort APB accesses with SLVERR after TIMEOUT wait cycles.
module friscv_axil_apb_bridge
    import friscv_bridge_pkg::*;
#(
    parameter int                   AXI_ADDRW = 32,
    parameter int                   ADDRW     = 16,
    parameter int                   XLEN      = 32,
    parameter logic [AXI_ADDRW-1:0] BASE_ADDR = 32'h0200_0000,
    parameter int                   TIMEOUT   = 255
)(
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 awvalid,
    output logic                 awready,
    input  logic [AXI_ADDRW-1:0] awaddr,
    input  logic                 wvalid,
    output logic                 wready,
    input  logic [XLEN-1:0]      wdata,
    input  logic [XLEN/8-1:0]    wstrb,
    output logic                 bvalid,
    input  logic                 bready,
    output logic [1:0]           bresp,
    input  logic                 arvalid,
    output logic                 arready,
    input  logic [AXI_ADDRW-1:0] araddr,
    output logic                 rvalid,
    input  logic                 rready,
    output logic [XLEN-1:0]      rdata,
    output logic [1:0]           rresp,
    output logic                 mst_en,
    output logic                 mst_wr,
    output logic [ADDRW-1:0]     mst_addr,
    output logic [XLEN-1:0]      mst_wdata,
    output logic [XLEN/8-1:0]    mst_strb,
    input  logic [XLEN-1:0]      mst_rdata,
    input  logic                 mst_ready
);

    state_t               state;
    logic [1:0]           grant;
    logic [1:0]           resp;
    logic                 acc_wr;
    logic [AXI_ADDRW-1:0] acc_addr;
    logic                 in_win;

    friscv_rr_arb2 arb (
        .aclk   (aclk),
        .areset (areset),
        .en     (state == IDLE),
        .req    ({arvalid, awvalid && wvalid}),
        .grant  (grant)
    );

    assign awready  = grant[0];
    assign wready   = grant[0];
    assign arready  = grant[1];
    assign acc_wr   = grant[0];
    assign acc_addr = acc_wr ? awaddr : araddr;
    assign in_win   = acc_addr[AXI_ADDRW-1:ADDRW] == BASE_ADDR[AXI_ADDRW-1:ADDRW];
    assign bresp    = resp;
    assign rresp    = resp;

`ifdef FRISCV_BRIDGE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic          expired;
    // the cycle that would bring the count to TIMEOUT is the last one mst_en stays high
    assign expired = cnt == CW'(TIMEOUT - 1);
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            bvalid    <= 1'b0;
            rvalid    <= 1'b0;
            resp      <= OKAY;
            rdata     <= '0;
            mst_en    <= 1'b0;
            mst_wr    <= 1'b0;
            mst_addr  <= '0;
            mst_wdata <= '0;
            mst_strb  <= '0;
`ifdef FRISCV_BRIDGE_TIMEOUT_EN
            cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef FRISCV_BRIDGE_TIMEOUT_EN
                    cnt <= '0;
`endif
                    if (|grant) begin
                        if (in_win) begin
                            mst_wr    <= acc_wr;
                            mst_addr  <= acc_addr[ADDRW-1:0];
                            mst_wdata <= wdata;
                            mst_strb  <= wstrb;
                            mst_en    <= 1'b1;
                            state     <= ACCESS;
                        end else begin
                            resp   <= DECERR;
                            rdata  <= '0;
                            bvalid <= acc_wr;
                            rvalid <= !acc_wr;
                            state  <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    if (mst_ready) begin
                        rdata  <= mst_wr ? rdata : mst_rdata;
                        resp   <= OKAY;
                        mst_en <= 1'b0;
                        bvalid <= mst_wr;
                        rvalid <= !mst_wr;
                        state  <= RESP;
                    end
`ifdef FRISCV_BRIDGE_TIMEOUT_EN
                    else if (expired) begin
                        rdata  <= '0;
                        resp   <= SLVERR;
                        mst_en <= 1'b0;
                        bvalid <= mst_wr;
                        rvalid <= !mst_wr;
                        state  <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if ((bvalid && bready) || (rvalid && rready)) begin
                        bvalid <= 1'b0;
                        rvalid <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_friscv_axil_apb_bridge.sv
// tb_friscv_axil_apb_bridge: randomized bench with a CLINT-like slave and a word-array reference model.
module tb_friscv_axil_apb_bridge;

    localparam int TO = 4;

    logic        aclk = 1'b0, areset = 1'b1;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, bready = 1'b0, rready = 1'b0;
    logic        awready, wready, arready, bvalid, rvalid;
    logic [31:0] awaddr = '0, araddr = '0, wdata = '0;
    logic [3:0]  wstrb = '0;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        mst_en, mst_wr, mst_ready;
    logic [15:0] mst_addr;
    logic [31:0] mst_wdata, mst_rdata;
    logic [3:0]  mst_strb;

    int          total = 0, bad = 0, cyc = 0, en_total = 0, en_rise = -1;
    logic        en_q = 1'b0, stall = 1'b0, late_pulse = 1'b0;
    logic [31:0] smem [16];
    logic [15:0] s_addr;
    logic [31:0] s_wdata;
    logic        s_wr;
    logic [31:0] ref_mem [16];
    bit          last_wr;

    friscv_axil_apb_bridge #(
        .AXI_ADDRW(32), .ADDRW(16), .XLEN(32), .BASE_ADDR(32'h0200_0000), .TIMEOUT(TO)
    ) dut (
        .aclk(aclk), .areset(areset),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .mst_en(mst_en), .mst_wr(mst_wr), .mst_addr(mst_addr), .mst_wdata(mst_wdata),
        .mst_strb(mst_strb), .mst_rdata(mst_rdata), .mst_ready(mst_ready)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    always @(negedge aclk) begin
        if (mst_en) en_total <= en_total + 1;
        if (mst_en && !en_q) en_rise <= cyc;
        en_q <= mst_en;
    end

    // CLINT-like peripheral: answers one cycle after seeing a fresh request
    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            mst_ready <= 1'b0;
            mst_rdata <= '0;
            for (int i = 0; i < 16; i++) smem[i] <= '0;
        end else begin
            mst_ready <= (mst_en && !mst_ready && !stall) || late_pulse;
            if (mst_en && !mst_ready) begin
                mst_rdata <= smem[mst_addr[5:2]];
                s_addr    <= mst_addr;
                s_wdata   <= mst_wdata;
                s_wr      <= mst_wr;
                if (mst_wr)
                    for (int b = 0; b < 4; b++)
                        if (mst_strb[b]) smem[mst_addr[5:2]][8*b +: 8] <= mst_wdata[8*b +: 8];
            end
        end
    end

    task automatic do_reset;
        areset = 1'b1; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; stall = 1'b0; late_pulse = 1'b0;
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        last_wr = 1'b0;
    endtask

    task automatic axi_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output int ta, output int tr);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        ta = -1; tr = -1; resp = 2'bxx;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (awready && wready) begin ta = cyc; break; end
        end
        @(posedge aclk); #1 awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge aclk);
            if (bvalid) begin tr = cyc; resp = bresp; break; end
        end
        @(posedge aclk); #1;
    endtask

    task automatic axi_rd(input logic [31:0] a, output logic [1:0] resp, output logic [31:0] d,
                          output int ta, output int tr);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        ta = -1; tr = -1; resp = 2'bxx; d = 'x;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (arready) begin ta = cyc; break; end
        end
        @(posedge aclk); #1 arvalid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge aclk);
            if (rvalid) begin tr = cyc; resp = rresp; d = rdata; break; end
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_reset;
        do_reset;
        @(negedge aclk);
        total++; if (mst_en !== 1'b0 || mst_wr !== 1'b0) begin bad++; $display("FAIL reset_mst en=%b wr=%b exp 0 0", mst_en, mst_wr); end
        total++; if (bvalid !== 1'b0 || rvalid !== 1'b0) begin bad++; $display("FAIL reset_valid b=%b r=%b exp 0 0", bvalid, rvalid); end
        total++; if (awready !== 1'b0 || wready !== 1'b0 || arready !== 1'b0) begin bad++; $display("FAIL reset_ready aw=%b w=%b ar=%b exp 0", awready, wready, arready); end
        total++; if (mst_addr !== 16'h0 || mst_wdata !== 32'h0 || mst_strb !== 4'h0) begin bad++; $display("FAIL reset_req addr=%h wdata=%h strb=%h exp 0", mst_addr, mst_wdata, mst_strb); end
        total++; if (rdata !== 32'h0 || bresp !== 2'b00 || rresp !== 2'b00) begin bad++; $display("FAIL reset_resp rdata=%h bresp=%b rresp=%b exp 0", rdata, bresp, rresp); end
        @(posedge aclk); #1;
    endtask

    task automatic test_write;
        logic [1:0] r; int ta, tr, e0;
        e0 = en_total;
        axi_wr(32'h0200_0010, 32'h0000_0005, 4'hF, r, ta, tr);
        ref_mem[4] = 32'h5;
        total++; if (ta < 0) begin bad++; $display("FAIL write_accept got=%0d exp accepted", ta); end
        total++; if (en_rise !== ta + 1) begin bad++; $display("FAIL write_en_cycle got=%0d exp=%0d", en_rise, ta + 1); end
        total++; if (tr !== ta + 3) begin bad++; $display("FAIL write_bvalid_cycle got=%0d exp=%0d", tr, ta + 3); end
        total++; if (r !== 2'b00) begin bad++; $display("FAIL write_bresp got=%b exp=00", r); end
        total++; if (en_total - e0 !== 2) begin bad++; $display("FAIL write_en_len got=%0d exp=2", en_total - e0); end
        total++; if (s_addr !== 16'h0010 || s_wdata !== 32'h5 || s_wr !== 1'b1) begin bad++; $display("FAIL write_req addr=%h data=%h wr=%b exp 0010 00000005 1", s_addr, s_wdata, s_wr); end
    endtask

    task automatic test_read;
        logic [1:0] r; logic [31:0] d; int ta, tr;
        axi_wr(32'h0200_0008, 32'h1234_5678, 4'hF, r, ta, tr);
        ref_mem[2] = 32'h1234_5678;
        axi_rd(32'h0200_0008, r, d, ta, tr);
        total++; if (tr !== ta + 3 || ta < 0) begin bad++; $display("FAIL read_rvalid_cycle got=%0d exp=%0d", tr, ta + 3); end
        total++; if (d !== 32'h1234_5678) begin bad++; $display("FAIL read_rdata got=%h exp=12345678", d); end
        total++; if (r !== 2'b00) begin bad++; $display("FAIL read_rresp got=%b exp=00", r); end
        total++; if (s_wr !== 1'b0 || s_addr !== 16'h0008) begin bad++; $display("FAIL read_req wr=%b addr=%h exp 0 0008", s_wr, s_addr); end
        total++; if (en_rise !== ta + 1) begin bad++; $display("FAIL read_en_cycle got=%0d exp=%0d", en_rise, ta + 1); end
    endtask

    task automatic test_decerr;
        logic [1:0] r; logic [31:0] d, v; int ta, tr, e0;
        e0 = en_total;
        axi_rd(32'h0300_0000, r, d, ta, tr);
        total++; if (r !== 2'b11 || d !== 32'h0) begin bad++; $display("FAIL decerr_read resp=%b rdata=%h exp 11 0", r, d); end
        total++; if (tr !== ta + 1 || ta < 0) begin bad++; $display("FAIL decerr_read_cycle got=%0d exp=%0d", tr, ta + 1); end
        axi_wr(32'h0201_0000, 32'hDEAD_BEEF, 4'hF, r, ta, tr);
        total++; if (r !== 2'b11 || tr !== ta + 1) begin bad++; $display("FAIL decerr_write resp=%b lat=%0d exp 11 1", r, tr - ta); end
        axi_rd(32'h01FF_FFFC, r, d, ta, tr);
        total++; if (r !== 2'b11) begin bad++; $display("FAIL decerr_below resp=%b exp=11", r); end
        total++; if (en_total !== e0) begin bad++; $display("FAIL decerr_no_en got=%0d exp=0", en_total - e0); end
        v = $urandom;
        axi_wr(32'h0200_FFFC, v, 4'hF, r, ta, tr);
        ref_mem[15] = v;
        axi_rd(32'h0200_FFFC, r, d, ta, tr);
        total++; if (r !== 2'b00 || d !== ref_mem[15]) begin bad++; $display("FAIL window_top resp=%b rdata=%h exp 00 %h", r, d, ref_mem[15]); end
    endtask

    task automatic test_backpressure;
        logic [1:0] r; logic [31:0] hold; int ta, tr; bit seen;
        axi_wr(32'h0200_0004, $urandom, 4'hF, r, ta, tr); ref_mem[1] = wdata;
        axi_wr(32'h0200_0008, $urandom, 4'hF, r, ta, tr); ref_mem[2] = wdata;
        araddr = 32'h0200_0004; arvalid = 1'b1; rready = 1'b0; seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin @(negedge aclk); seen = arready; end
        @(posedge aclk); #1 araddr = 32'h0200_0008;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin @(negedge aclk); seen = rvalid; end
        hold = rdata;
        total++; if (!seen || hold !== ref_mem[1]) begin bad++; $display("FAIL bp_first seen=%b rdata=%h exp %h", seen, hold, ref_mem[1]); end
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            total++; if (rvalid !== 1'b1 || rdata !== hold || arready !== 1'b0) begin bad++; $display("FAIL bp_hold%0d rvalid=%b rdata=%h arready=%b exp 1 %h 0", i, rvalid, rdata, arready, hold); end
        end
        @(posedge aclk); #1 rready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin @(negedge aclk); seen = arready; end
        @(posedge aclk); #1 arvalid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin @(negedge aclk); seen = rvalid; hold = rdata; end
        total++; if (!seen || hold !== ref_mem[2]) begin bad++; $display("FAIL bp_second seen=%b rdata=%h exp %h", seen, hold, ref_mem[2]); end
        @(posedge aclk); #1;
    endtask

    task automatic test_collision(input int nw, input int nr);
        int wl, rl, widx, ridx; bit pw, pr, w_hs, r_hs, exp_rd; logic [31:0] ev; logic [31:0] exp_q[$];
        do_reset;
        wl = nw; rl = nr; bready = 1'b1; rready = 1'b1;
        widx = $urandom_range(0, 15); ridx = $urandom_range(0, 15);
        awaddr = 32'h0200_0000 + 32'(widx * 4); wdata = $urandom; wstrb = 4'hF;
        awvalid = wl > 0; wvalid = wl > 0;
        araddr = 32'h0200_0000 + 32'(ridx * 4); arvalid = rl > 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge aclk);
            pw = awvalid && wvalid; pr = arvalid;
            w_hs = pw && awready && wready; r_hs = pr && arready;
            if (w_hs || r_hs) begin
                exp_rd = (pw && pr) ? last_wr : pr;
                total++; if (r_hs !== exp_rd || w_hs === r_hs) begin bad++; $display("FAIL collision_grant cyc=%0d got_rd=%b got_wr=%b exp_rd=%b", cyc, r_hs, w_hs, exp_rd); end
                last_wr = w_hs;
                if (w_hs) ref_mem[widx] = wdata;
                if (r_hs) exp_q.push_back(ref_mem[ridx]);
            end
            if (rvalid) begin
                ev = exp_q.size() > 0 ? exp_q.pop_front() : 32'hxxxx_xxxx;
                total++; if (rdata !== ev || rresp !== 2'b00) begin bad++; $display("FAIL collision_rdata got=%h/%b exp=%h/00", rdata, rresp, ev); end
            end
            if (bvalid) begin
                total++; if (bresp !== 2'b00) begin bad++; $display("FAIL collision_bresp got=%b exp=00", bresp); end
            end
            @(posedge aclk); #1;
            if (w_hs) begin
                wl--; widx = $urandom_range(0, 15);
                awaddr = 32'h0200_0000 + 32'(widx * 4); wdata = $urandom;
                awvalid = wl > 0; wvalid = wl > 0;
            end
            if (r_hs) begin
                rl--; ridx = $urandom_range(0, 15);
                araddr = 32'h0200_0000 + 32'(ridx * 4); arvalid = rl > 0;
            end
        end
        total++; if (wl != 0 || rl != 0 || exp_q.size() != 0) begin bad++; $display("FAIL collision_done wl=%0d rl=%0d q=%0d exp 0 0 0", wl, rl, exp_q.size()); end
    endtask

    task automatic test_random;
        logic [1:0] r; logic [31:0] a, d, v; logic [3:0] s; int ta, tr, idx; bit inwin;
        for (int n = 0; n < 40; n++) begin
            inwin = $urandom_range(0, 4) != 0;
            idx = $urandom_range(0, 15);
            a = $urandom;
            if (inwin) a = 32'h0200_0000 + 32'(idx * 4);
            else if (a[31:16] == 16'h0200) a[31:16] = 16'h0300;
            if ($urandom_range(0, 1) == 1) begin
                v = $urandom; s = 4'($urandom_range(0, 15));
                axi_wr(a, v, s, r, ta, tr);
                if (inwin) for (int b = 0; b < 4; b++) if (s[b]) ref_mem[idx][8*b +: 8] = v[8*b +: 8];
                total++; if (r !== (inwin ? 2'b00 : 2'b11) || tr - ta !== (inwin ? 3 : 1) || ta < 0) begin bad++; $display("FAIL rand_wr%0d addr=%h resp=%b lat=%0d exp in=%b", n, a, r, tr - ta, inwin); end
            end else begin
                axi_rd(a, r, d, ta, tr);
                total++; if (r !== (inwin ? 2'b00 : 2'b11) || d !== (inwin ? ref_mem[idx] : 32'h0) || tr - ta !== (inwin ? 3 : 1) || ta < 0) begin bad++; $display("FAIL rand_rd%0d addr=%h resp=%b rdata=%h lat=%0d exp in=%b data=%h", n, a, r, d, tr - ta, inwin, inwin ? ref_mem[idx] : 32'h0); end
            end
        end
    endtask

`ifdef FRISCV_BRIDGE_TIMEOUT_EN
    task automatic test_timeout;
        logic [1:0] r; logic [31:0] d; int ta, tr, e0;
        stall = 1'b1; e0 = en_total;
        axi_rd(32'h0200_0000, r, d, ta, tr);
        stall = 1'b0;
        total++; if (en_total - e0 !== TO) begin bad++; $display("FAIL timeout_en_len got=%0d exp=%0d", en_total - e0, TO); end
        total++; if (r !== 2'b10 || d !== 32'h0) begin bad++; $display("FAIL timeout_resp resp=%b rdata=%h exp 10 0", r, d); end
        total++; if (tr !== ta + TO + 1) begin bad++; $display("FAIL timeout_cycle got=%0d exp=%0d", tr, ta + TO + 1); end
        late_pulse = 1'b1;
        @(posedge aclk); #1 late_pulse = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge aclk);
            total++; if (rvalid !== 1'b0 || bvalid !== 1'b0) begin bad++; $display("FAIL timeout_late%0d rvalid=%b bvalid=%b exp 0 0", i, rvalid, bvalid); end
        end
        axi_rd(32'h0200_0000, r, d, ta, tr);
        total++; if (r !== 2'b00 || d !== ref_mem[0]) begin bad++; $display("FAIL timeout_recover resp=%b rdata=%h exp 00 %h", r, d, ref_mem[0]); end
    endtask
`endif

    task automatic test_reset_mid;
        logic [1:0] r; logic [31:0] d; int ta, tr; bit seen;
        axi_wr(32'h0200_0004, 32'hA5A5_0001, 4'hF, r, ta, tr);
        axi_rd(32'h0200_0004, r, d, ta, tr);
        araddr = 32'h0200_0004; arvalid = 1'b1; rready = 1'b1; seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin @(negedge aclk); seen = arready; end
        @(posedge aclk); #1 arvalid = 1'b0;
        @(negedge aclk);
        total++; if (mst_en !== 1'b1) begin bad++; $display("FAIL mid_en_before got=%b exp=1", mst_en); end
        #1 areset = 1'b1;
        #1;
        total++; if (mst_en !== 1'b0 || rvalid !== 1'b0 || rdata !== 32'h0 || mst_addr !== 16'h0) begin bad++; $display("FAIL mid_async en=%b rvalid=%b rdata=%h addr=%h exp 0", mst_en, rvalid, rdata, mst_addr); end
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        last_wr = 1'b0; late_pulse = 1'b1;
        @(posedge aclk); #1 late_pulse = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge aclk);
            total++; if (rvalid !== 1'b0 || bvalid !== 1'b0 || mst_en !== 1'b0) begin bad++; $display("FAIL mid_stray%0d rvalid=%b bvalid=%b en=%b exp 0", i, rvalid, bvalid, mst_en); end
        end
        axi_rd(32'h0200_0004, r, d, ta, tr);
        total++; if (r !== 2'b00 || d !== ref_mem[1] || tr !== ta + 3) begin bad++; $display("FAIL mid_after resp=%b rdata=%h lat=%0d exp 00 %h 3", r, d, tr - ta, ref_mem[1]); end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_decerr;
        test_backpressure;
        test_collision(1, 1);
        test_collision(2, 1);
        test_collision(3, 3);
        test_collision($urandom_range(1, 3), $urandom_range(1, 3));
        test_random;
`ifdef FRISCV_BRIDGE_TIMEOUT_EN
        test_timeout;
`endif
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
